// File: rtl/gpi_event_fifo_if.sv
// Data-memory bus slice between the SoC address decoder and gpi_event_fifo.
// The decoder/core side is the master; the peripheral is the slave.
interface gpi_event_fifo_if;
    logic        we;
    logic        re;
    logic [2:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output we, output re, output a, output wd, input rd);
    modport slave  (input we, input re, input a, input wd, output rd);
endinterface

// File: rtl/gpi_event_fifo.sv
// GPI change-event FIFO: masked edge detection on a 32-bit input bus, queued for the core.
// Define GPI_EVENT_TIMESTAMP_EN to store a free-running cycle stamp with each entry (read at a=4).
module gpi_event_fifo #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    gpi_event_fifo_if.slave    bus,
    input  logic [31:0]        gpi,
    output logic               irq
);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [31:0]      prev_gpi;
    logic [31:0]      mask;
    logic             ctrl_en;
    logic             ctrl_irq_en;
    logic             overflow;
    logic [31:0]      data_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic empty, full, evt, pop, push, drop, ctrl_wr, mask_wr, clr;
    logic        ts_flag;
    logic [31:0] ts_head;
    logic [31:0] status;

    always_comb begin
        empty   = (count == '0);
        full    = (count == DEPTH_C);
        evt     = ctrl_en & (|((gpi ^ prev_gpi) & mask));
        pop     = bus.re & (bus.a == 3'd0) & ~empty;
        // A full FIFO still accepts an event when the head leaves in the same edge.
        push    = evt & (~full | pop);
        drop    = evt & full & ~pop;
        ctrl_wr = bus.we & (bus.a == 3'd2);
        mask_wr = bus.we & (bus.a == 3'd3);
        clr     = ctrl_wr & bus.wd[1];
    end

    always_ff @(posedge clk) begin
        prev_gpi <= gpi;
        if (rst) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            mask        <= '1;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl_en     <= bus.wd[0];
                ctrl_irq_en <= bus.wd[2];
            end
            if (mask_wr) begin
                mask <= bus.wd;
            end
            if (clr) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop) begin
                    count <= count + (PTR_W+1)'(1);
                end else if (pop && !push) begin
                    count <= count - (PTR_W+1)'(1);
                end
                if (drop) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !clr) begin
            data_mem[wr_ptr] <= gpi;
        end
    end

`ifdef GPI_EVENT_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] ts_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
        end
    end

    // The stamp is the counter value at the push edge, i.e. before it advances.
    always_ff @(posedge clk) begin
        if (push && !rst && !clr) begin
            ts_mem[wr_ptr] <= ts_cnt;
        end
    end

    assign ts_flag = 1'b1;
    assign ts_head = empty ? 32'd0 : ts_mem[rd_ptr];
`else
    assign ts_flag = 1'b0;
    assign ts_head = 32'd0;
`endif

    assign status = {16'h0000, 8'(count), 4'h0, ts_flag, overflow, full, empty};

    always_comb begin
        bus.rd = 32'd0;
        case (bus.a)
            3'd0:    bus.rd = empty ? 32'd0 : data_mem[rd_ptr];
            3'd1:    bus.rd = status;
            3'd2:    bus.rd = {29'd0, ctrl_irq_en, 1'b0, ctrl_en};
            3'd3:    bus.rd = mask;
            3'd4:    bus.rd = ts_head;
            default: bus.rd = 32'd0;
        endcase
    end

    assign irq = ctrl_irq_en & ~empty;

endmodule

// File: tb/tb_gpi_event_fifo.sv
// Scoreboard bench for gpi_event_fifo: queue-based reference model, directed plus random stimulus.
module tb_gpi_event_fifo;
    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic [31:0] gpi;
    logic        irq;

    gpi_event_fifo_if bus ();

    gpi_event_fifo #(.DEPTH(DEPTH), .PTR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .gpi (gpi),
        .irq (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          chk_rd;
        logic [2:0]  a;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic [31:0] t;
    } ent_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    ent_t        mq[$];
    logic        m_ovf, m_en, m_irq_en;
    logic [31:0] m_mask, m_prev, m_cyc;
    logic [31:0] gv;

`ifdef GPI_EVENT_TIMESTAMP_EN
    localparam bit TS = 1'b1;
`else
    localparam bit TS = 1'b0;
`endif

    function automatic logic [31:0] model_rd(input logic [2:0] aa);
        logic [31:0] v;
        v = 32'd0;
        case (aa)
            3'd0: v = (mq.size() == 0) ? 32'd0 : mq[0].d;
            3'd1: begin
                v[0]    = (mq.size() == 0);
                v[1]    = (mq.size() == DEPTH);
                v[2]    = m_ovf;
                v[3]    = TS;
                v[15:8] = 8'(mq.size());
            end
            3'd2: v = {29'd0, m_irq_en, 1'b0, m_en};
            3'd3: v = m_mask;
            3'd4: v = (TS && mq.size() != 0) ? mq[0].t : 32'd0;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    task automatic model_edge(input logic r, input logic w, input logic rr,
                              input logic [2:0] aa, input logic [31:0] d, input logic [31:0] g);
        bit evt, pop, was_full;
        ent_t e;
        if (r) begin
            mq.delete();
            m_ovf = 0; m_en = 0; m_irq_en = 0;
            m_mask = 32'hFFFF_FFFF;
            m_prev = g;
            m_cyc  = 32'd0;
            return;
        end
        evt      = m_en && (((g ^ m_prev) & m_mask) != 0);
        pop      = rr && (aa == 3'd0) && (mq.size() != 0);
        was_full = (mq.size() == DEPTH);
        if (w && aa == 3'd2 && d[1]) begin
            mq.delete();
            m_ovf = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (evt) begin
                if (!was_full || pop) begin
                    e.d = g; e.t = m_cyc;
                    mq.push_back(e);
                end else begin
                    m_ovf = 1;
                end
            end
        end
        if (w && aa == 3'd2) begin
            m_en = d[0];
            m_irq_en = d[2];
        end
        if (w && aa == 3'd3) m_mask = d;
        m_prev = g;
        m_cyc  = m_cyc + 32'd1;
    endtask

    // One clock: drive inputs, queue the expected response, advance the model.
    task automatic step(input logic r, input logic w, input logic rr, input logic [2:0] aa,
                        input logic [31:0] d, input logic [31:0] g, input bit chk);
        exp_t e;
        rst = r; bus.we = w; bus.re = rr; bus.a = aa; bus.wd = d; gpi = g;
        gv = g;
        if (!r) begin
            e.chk_rd = chk;
            e.a      = aa;
            e.rd     = model_rd(aa);
            e.irq    = m_irq_en && (mq.size() != 0);
            sb.push_back(e);
        end
        model_edge(r, w, rr, aa, d, g);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] g);
        step(0, 0, 0, 3'd0, 32'd0, g, 0);
    endtask

    task automatic rd_reg(input logic [2:0] aa);
        step(0, 0, 1, aa, 32'd0, gv, 1);
    endtask

    task automatic wr_reg(input logic [2:0] aa, input logic [31:0] d);
        step(0, 1, 0, aa, d, gv, 0);
    endtask

    // Monitor: compares whatever the DUT presents mid-cycle against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (irq !== e.irq) begin
                n_err++;
                $display("FAIL irq: got %b expected %b at %0t", irq, e.irq, $time);
            end
            if (e.chk_rd) begin
                n_cmp++;
                if (bus.rd !== e.rd) begin
                    n_err++;
                    $display("FAIL rd a=%0d: got %h expected %h at %0t", e.a, bus.rd, e.rd, $time);
                end
            end
        end
    end

    initial begin
        gv = 32'd0;
        step(1, 0, 0, 3'd0, 32'd0, 32'd0, 0);
        step(1, 0, 0, 3'd0, 32'd0, 32'd0, 0);
        rd_reg(3'd1);
        rd_reg(3'd3);
        rd_reg(3'd2);
        rd_reg(3'd0);

        // Two events, drained in order
        wr_reg(3'd2, 32'h5);
        idle(32'hA); idle(32'hA); idle(32'hA);
        idle(32'h6); idle(32'h6);
        rd_reg(3'd1);
        rd_reg(3'd0); rd_reg(3'd0);
        rd_reg(3'd1);

        // Mask filtering
        wr_reg(3'd3, 32'h1);
        idle(gv ^ 32'h8); idle(gv);
        idle(gv ^ 32'h1); idle(gv);
        rd_reg(3'd1);
        rd_reg(3'd0);
        wr_reg(3'd3, 32'hFFFF_FFFF);

        // Overflow after 10 events, then clear with enable kept
        for (int i = 1; i <= 10; i++) idle(32'h100 * i + 32'h11);
        rd_reg(3'd1);
        for (int i = 0; i < 3; i++) rd_reg(3'd0);
        rd_reg(3'd1);
        wr_reg(3'd2, 32'h3);
        rd_reg(3'd1);
        rd_reg(3'd2);

        // Full with simultaneous event and pop
        for (int i = 1; i <= 8; i++) idle(32'hC000_0000 + i);
        step(0, 0, 1, 3'd0, 32'd0, gv ^ 32'h8000, 1);
        rd_reg(3'd1);
        for (int i = 0; i < 9; i++) rd_reg(3'd0);
        rd_reg(3'd1);

        // Timestamp spacing: events 5 cycles apart
        step(1, 0, 0, 3'd0, 32'd0, gv, 0);
        wr_reg(3'd2, 32'h1);
        for (int k = 0; k < 3; k++) begin
            idle(gv + 32'd1);
            for (int j = 0; j < 4; j++) idle(gv);
        end
        rd_reg(3'd1);
        for (int k = 0; k < 3; k++) begin
            rd_reg(3'd4);
            rd_reg(3'd0);
        end

        // Randomized traffic
        wr_reg(3'd2, 32'h5);
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] g, d;
            logic [2:0]  aa;
            logic        w, rr, r;
            g  = gv;
            if ($urandom_range(0, 1) == 1) g = g ^ (32'd1 << $urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) g = $urandom;
            r  = ($urandom_range(0, 599) == 0);
            w  = ($urandom_range(0, 15) == 0);
            rr = !w && ($urandom_range(0, 2) == 0);
            aa = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            d  = $urandom;
            if (w && aa == 3'd2) begin
                d[0] = ($urandom_range(0, 3) != 0);
                d[1] = ($urandom_range(0, 3) == 0);
            end
            if (w && aa == 3'd3 && $urandom_range(0, 1) == 0) d = 32'hFFFF_FFFF;
            step(r, w, rr, aa, d, g, 1);
        end

        idle(gv);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard drain: %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gpi_event_fifo.md
Name: gpi_event_fifo

Overview:
- Memory-mapped responder on the SoC data-memory bus. The MIPS core is the initiator.
- Samples the 32-bit general-purpose input bus every cycle and detects masked bit changes.
- On each detected change, pushes the new input word into a small FIFO. The core drains the FIFO with loads.
- Sits beside the GPIO and factorial-accelerator peripherals. It is selected by the SoC address decoder, and its read data is muxed into rd_dm.

Parameters:
- DEPTH, 8: FIFO entries; must be a power of two, 2..128.
- PTR_W, 3: log2(DEPTH).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- we  in  1  write strobe from the decoder (core we_dm qualified by this block's select)
- re  in  1  read strobe from the decoder; pulses once per load instruction in the M stage
- a  in  3  word address, byte address bits [4:2]
- wd  in  32  write data (core wd_dm)
- rd  out  32  read data, combinational from a
- gpi  in  32  input bus being monitored
- irq  out  1  level interrupt request

Behaviour:
- Register map (by a):
  - 0 DATA (RO): head entry. A read with re=1 pops the entry.
  - 1 STATUS (RO): bit0 empty; bit1 full; bit2 overflow (sticky); bits[15:8] count; all other bits 0.
  - 2 CTRL (RW): bit0 enable; bit1 clear (write-1 pulse, reads back 0); bit2 irq_en.
  - 3 MASK (RW): per-bit change mask.
  - 4 TSTAMP (RO): described under Optional Feature.
  - 5..7: read 0, writes ignored.
- Reset, in the cycle rst=1:
  - FIFO is empty; count=0; overflow=0; CTRL=0; MASK=0xFFFF_FFFF.
  - prev_gpi <= gpi, so no spurious event follows reset.
  - irq=0, and rd follows a with empty-FIFO values.
- Change detection:
  - prev_gpi <= gpi on every clock.
  - event = enable & |((gpi ^ prev_gpi) & MASK).
  - On an event, the current gpi value is pushed at that clock edge. Latency from a gpi change to the entry being visible at DATA is 1 clock.
- Pop:
  - Occurs on the clock edge where re=1 and a=0 and the FIFO is not empty.
  - A DATA read while the FIFO is empty returns 0 and does not pop. Pointers are unchanged.
- Full:
  - An event while full and without a simultaneous pop is dropped and sets overflow.
  - An event with a simultaneous pop while full pushes and pops. count stays at DEPTH and overflow is not set.
- Empty:
  - A simultaneous push and pop while empty is a push only; the pop is ignored.
  - The new entry appears at DATA on the next cycle. There is no bypass.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH, width PTR_W+1, saturating only logically via full.
- Clear:
  - A CTRL write with bit1=1 flushes the FIFO and clears overflow in that edge. It overrides any push or pop in the same cycle.
  - Bits 0 and 2 of the same write still take effect.
- A write to any register and an event in the same cycle are both honoured. A new enable or MASK value applies from the next cycle.
- irq = irq_en & ~empty, registered-free (combinational from state).
- Reset asserted mid-operation discards all entries in one clock. No partial state survives.

Optional Feature:
- Macro: GPI_EVENT_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter is reset to 0 and increments every clock, wrapping at 2^32.
  - Each pushed entry also stores the counter value from the push edge.
  - a=4 returns the head entry's timestamp (0 if empty). Reading TSTAMP never pops.
  - STATUS bit3 reads 1.
- Undefined:
  - No counter or timestamp storage is built.
  - a=4 reads 0 and STATUS bit3 reads 0.

Test Plan:
- Reset then read STATUS -> 0x0000_0001. Read MASK -> 0xFFFF_FFFF. irq=0.
- CTRL=0x5; gpi 0x0 -> 0xA, then 0xA -> 0x6 on later cycles -> STATUS count=2 and irq=1. Two DATA reads return 0xA then 0x6. STATUS is then 0x1 and irq=0.
- MASK=0x1, enable; toggle gpi bit3 -> no push. Toggle bit0 -> exactly one push.
- DEPTH=8: 10 events with no reads -> STATUS=0x0000_0806 (count 8, full, overflow). Entries read back are events 1..8 in order. CTRL write 0x3 -> STATUS=0x1, overflow cleared, enable kept.
- Full FIFO with an event and DATA read in the same cycle -> read returns the oldest entry, count stays 8, overflow stays 0. DATA read while empty -> 0, count 0.
- With GPI_EVENT_TIMESTAMP_EN: events 5 cycles apart after reset -> TSTAMP delta between consecutive entries = 5, and STATUS bit3=1.
